// File: rtl/crc_sched_pkg.sv
// Shared types and constants for the CRC request scheduler.
// Holds the FSM state encoding, the reset polynomial and the error-counter limits.
package crc_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_RESP
    } state_e;

    localparam logic [3:0] RST_POLY_DEFAULT = 4'b1011;

    localparam int                   ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: grants the first active request at or after ptr_i.
// The search wraps modulo NREQ, and the result is both a one-hot grant and an index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(ptr_i) + i) % NREQ);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/crc_req_sched.sv
// Round-robin scheduler that time-shares one external combinational CRC datapath.
// Also owns the polynomial configuration and a saturating count of check mismatches.
module crc_req_sched
    import crc_sched_pkg::*;
#(
    parameter int               NREQ     = 4,
    parameter int               WCODE    = 4,
    parameter int               WPOLY    = 4,
    parameter logic [WPOLY-1:0] RST_POLY = WPOLY'(RST_POLY_DEFAULT)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NREQ-1:0]             i_req_valid,
    input  logic [NREQ*WCODE-1:0]       i_req_data,
    input  logic [NREQ-1:0]             i_req_check,
    input  logic [NREQ*(WPOLY-1)-1:0]   i_req_crc,
    output logic [NREQ-1:0]             o_req_ready,
    output logic [WCODE-1:0]            o_crc_data,
    output logic [WPOLY-1:0]            o_crc_poly,
    input  logic [WPOLY-2:0]            i_crc_result,
    output logic                        o_rsp_valid,
    input  logic                        i_rsp_ready,
    output logic [$clog2(NREQ)-1:0]     o_rsp_id,
    output logic [WPOLY-2:0]            o_rsp_crc,
    output logic                        o_rsp_err,
    input  logic                        i_cfg_we,
    input  logic [WPOLY-1:0]            i_cfg_poly,
    output logic                        o_cfg_err,
    output logic                        o_busy,
    output logic [ERR_CNT_W-1:0]        o_err_cnt
);

    localparam int IW   = $clog2(NREQ);
    localparam int WCRC = WPOLY - 1;

    state_e                 state_q;
    logic [IW-1:0]          rrPtr_q, rrPtr_d;
    logic [IW-1:0]          id_q;
    logic [WCODE-1:0]       data_q;
    logic                   check_q;
    logic [WCRC-1:0]        rxCrc_q;
    logic [WCRC-1:0]        rspCrc_q;
    logic                   rspErr_q;
    logic [ERR_CNT_W-1:0]   errCnt_q, errCnt_d;
    logic [WPOLY-1:0]       polyActive_q;
    logic [WPOLY-1:0]       polyShadow_q, polyShadow_d;
    logic                   cfgErr_q;

    logic [NREQ-1:0]        grant;
    logic [IW-1:0]          grantIdx;
    logic                   grantAny;
    logic                   calcErr;
    logic                   cfgReject;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i   (i_req_valid),
        .ptr_i   (rrPtr_q),
        .grant_o (grant),
        .idx_o   (grantIdx),
        .any_o   (grantAny)
    );

    assign calcErr      = (state_q == ST_CALC) && check_q && (i_crc_result != rxCrc_q);
    assign errCnt_d     = (calcErr && (errCnt_q != ERR_CNT_MAX)) ? errCnt_q + 1'b1 : errCnt_q;
    assign cfgReject    = i_cfg_we && !i_cfg_poly[WPOLY-1];
    assign polyShadow_d = (i_cfg_we && i_cfg_poly[WPOLY-1]) ? i_cfg_poly : polyShadow_q;
    assign rrPtr_d      = (id_q == IW'(NREQ - 1)) ? '0 : id_q + 1'b1;

    // polyActive only follows the shadow in IDLE, so a job in flight keeps its polynomial.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            rrPtr_q      <= '0;
            id_q         <= '0;
            data_q       <= '0;
            check_q      <= 1'b0;
            rxCrc_q      <= '0;
            rspCrc_q     <= '0;
            rspErr_q     <= 1'b0;
            errCnt_q     <= '0;
            polyActive_q <= RST_POLY;
            polyShadow_q <= RST_POLY;
            cfgErr_q     <= 1'b0;
        end else begin
            polyShadow_q <= polyShadow_d;
            cfgErr_q     <= cfgReject;
            errCnt_q     <= errCnt_d;
            unique case (state_q)
                ST_IDLE: begin
                    polyActive_q <= polyShadow_q;
                    if (grantAny) begin
                        id_q    <= grantIdx;
                        data_q  <= i_req_data[grantIdx*WCODE +: WCODE];
                        check_q <= i_req_check[grantIdx];
                        rxCrc_q <= i_req_crc[grantIdx*WCRC +: WCRC];
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    rspCrc_q <= i_crc_result;
                    rspErr_q <= calcErr;
                    state_q  <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        rrPtr_q <= rrPtr_d;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_req_ready = (state_q == ST_IDLE) ? grant : '0;
    assign o_crc_data  = (state_q == ST_CALC) ? data_q : '0;
    assign o_crc_poly  = (state_q == ST_CALC) ? polyActive_q : '0;
    assign o_rsp_valid = (state_q == ST_RESP);
    assign o_rsp_id    = id_q;
    assign o_rsp_crc   = rspCrc_q;
    assign o_rsp_err   = rspErr_q;
    assign o_cfg_err   = cfgErr_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_err_cnt   = errCnt_q;

endmodule

// File: tb/tb_crc_req_sched.sv
// Self-checking bench for crc_req_sched: a cycle-level job model compared every cycle,
// plus directed jobs with hand-computed CRCs, grant orders and counter values.
module tb_crc_req_sched;

    localparam int NREQ  = 4;
    localparam int WCODE = 4;
    localparam int WPOLY = 4;
    localparam int WCRC  = 3;

    logic                    i_clk = 1'b0;
    logic                    i_rst = 1'b1;
    logic [NREQ-1:0]         i_req_valid = '0;
    logic [NREQ*WCODE-1:0]   i_req_data = '0;
    logic [NREQ-1:0]         i_req_check = '0;
    logic [NREQ*WCRC-1:0]    i_req_crc = '0;
    logic [NREQ-1:0]         o_req_ready;
    logic [WCODE-1:0]        o_crc_data;
    logic [WPOLY-1:0]        o_crc_poly;
    logic [WCRC-1:0]         i_crc_result;
    logic                    o_rsp_valid;
    logic                    i_rsp_ready = 1'b1;
    logic [1:0]              o_rsp_id;
    logic [WCRC-1:0]         o_rsp_crc;
    logic                    o_rsp_err;
    logic                    i_cfg_we = 1'b0;
    logic [WPOLY-1:0]        i_cfg_poly = '0;
    logic                    o_cfg_err;
    logic                    o_busy;
    logic [7:0]              o_err_cnt;

    int checks = 0;
    int errors = 0;

    crc_req_sched #(
        .NREQ  (NREQ),
        .WCODE (WCODE),
        .WPOLY (WPOLY)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .i_req_data   (i_req_data),
        .i_req_check  (i_req_check),
        .i_req_crc    (i_req_crc),
        .o_req_ready  (o_req_ready),
        .o_crc_data   (o_crc_data),
        .o_crc_poly   (o_crc_poly),
        .i_crc_result (i_crc_result),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_id     (o_rsp_id),
        .o_rsp_crc    (o_rsp_crc),
        .o_rsp_err    (o_rsp_err),
        .i_cfg_we     (i_cfg_we),
        .i_cfg_poly   (i_cfg_poly),
        .o_cfg_err    (o_cfg_err),
        .o_busy       (o_busy),
        .o_err_cnt    (o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Polynomial long division of data * x^3 by poly: the external CRC datapath.
    function automatic logic [2:0] crcCalc(input logic [3:0] d, input logic [3:0] p);
        logic [6:0] r;
        r = {d, 3'b000};
        for (int i = 6; i >= 3; i--)
            if (r[i]) r = r ^ ({3'b000, p} << (i - 3));
        return r[2:0];
    endfunction

    assign i_crc_result = crcCalc(o_crc_data, o_crc_poly);

    function automatic int pickReq(input logic [3:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++)
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Job-level model: one job at a time, age 0 = datapath cycle, age >= 1 = awaiting consumer.
    bit         mLive = 1'b0;
    bit         mJob = 1'b0;
    int         mAge = 0;
    int         mId = 0;
    logic [3:0] mData = '0;
    logic [3:0] mPoly = '0;
    bit         mChk = 1'b0;
    logic [2:0] mRx = '0;
    int         mPtr = 0;
    logic [3:0] mShadow = 4'b1011;
    int         mErrCnt = 0;
    bit         mCfgErr = 1'b0;

    always @(posedge i_clk) begin
        logic [3:0] oldShadow;
        int g;
        if (i_rst) begin
            mLive = 1'b1; mJob = 1'b0; mAge = 0; mPtr = 0;
            mShadow = 4'b1011; mErrCnt = 0; mCfgErr = 1'b0;
        end else if (mLive) begin
            oldShadow = mShadow;
            if (!mJob) begin
                g = pickReq(i_req_valid, mPtr);
                if (g >= 0) begin
                    mJob = 1'b1; mAge = 0; mId = g;
                    mData = i_req_data[g*4 +: 4];
                    mChk = i_req_check[g];
                    mRx = i_req_crc[g*3 +: 3];
                    mPoly = oldShadow;
                end
            end else if (mAge == 0) begin
                mAge = 1;
                if (mChk && (crcCalc(mData, mPoly) != mRx) && (mErrCnt < 255)) mErrCnt++;
            end else if (i_rsp_ready) begin
                mJob = 1'b0;
                mPtr = (mId + 1) % NREQ;
            end
            mCfgErr = i_cfg_we && !i_cfg_poly[3];
            if (i_cfg_we && i_cfg_poly[3]) mShadow = i_cfg_poly;
        end
    end

    always @(negedge i_clk) begin
        int g;
        logic [2:0] eCrc;
        if (mLive) begin
            g = pickReq(i_req_valid, mPtr);
            checkOutput("req_ready", 32'(o_req_ready), (!mJob && g >= 0) ? (32'd1 << g) : 32'd0);
            checkOutput("crc_data", 32'(o_crc_data), (mJob && mAge == 0) ? 32'(mData) : 32'd0);
            checkOutput("crc_poly", 32'(o_crc_poly), (mJob && mAge == 0) ? 32'(mPoly) : 32'd0);
            checkOutput("rsp_valid", 32'(o_rsp_valid), 32'(mJob && mAge >= 1));
            if (mJob && mAge >= 1) begin
                eCrc = crcCalc(mData, mPoly);
                checkOutput("rsp_id", 32'(o_rsp_id), 32'(mId));
                checkOutput("rsp_crc", 32'(o_rsp_crc), 32'(eCrc));
                checkOutput("rsp_err", 32'(o_rsp_err), 32'(mChk && (eCrc != mRx)));
            end
            checkOutput("busy", 32'(o_busy), 32'(mJob));
            checkOutput("err_cnt", 32'(o_err_cnt), 32'(mErrCnt));
            checkOutput("cfg_err", 32'(o_cfg_err), 32'(mCfgErr));
        end
    end

    logic [3:0] lastReady;
    logic [3:0] lastCalcPoly;
    logic [1:0] lastId;
    logic [2:0] lastCrc;
    logic       lastErr;
    logic       lastCfgErr;
    int         lastLat;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic doReset();
        i_rst = 1'b1;
        i_req_valid = '0;
        i_cfg_we = 1'b0;
        i_rsp_ready = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    // One complete job; an optional config write is issued during its datapath cycle.
    task automatic applyStimulus(input int id, input logic [3:0] data, input bit chk,
                                 input logic [2:0] rx, input bit cfgWe, input logic [3:0] cfgPoly);
        bit seen;
        i_req_data[id*4 +: 4] = data;
        i_req_check[id] = chk;
        i_req_crc[id*3 +: 3] = rx;
        i_req_valid[id] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge i_clk);
            if (o_req_ready[id]) begin
                seen = 1'b1;
                lastReady = o_req_ready;
            end
        end
        checkOutput("accept_seen", 32'(seen), 32'd1);
        tick();
        i_req_valid[id] = 1'b0;
        i_cfg_we = cfgWe;
        i_cfg_poly = cfgPoly;
        @(negedge i_clk);
        lastCalcPoly = o_crc_poly;
        tick();
        i_cfg_we = 1'b0;
        lastLat = 1;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge i_clk);
            lastLat++;
            if (o_rsp_valid) begin
                seen = 1'b1;
                lastId = o_rsp_id;
                lastCrc = o_rsp_crc;
                lastErr = o_rsp_err;
                lastCfgErr = o_cfg_err;
            end
        end
        checkOutput("rsp_seen", 32'(seen), 32'd1);
        tick();
    endtask

    task automatic drainIdle();
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < 40 && !idle; c++) begin
            @(negedge i_clk);
            if (!o_busy) idle = 1'b1;
        end
        checkOutput("drain_idle", 32'(idle), 32'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int gIdx[8];
        int gCyc[8];
        int nG;
        bit seen;

        doReset();
        @(negedge i_clk);
        checkOutput("reset_busy", 32'(o_busy), 32'd0);
        checkOutput("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
        checkOutput("reset_err_cnt", 32'(o_err_cnt), 32'd0);
        tick();

        $display("[TB] generate job on requester 0");
        applyStimulus(0, 4'b1101, 1'b0, 3'b000, 1'b0, 4'b0000);
        checkOutput("t1_ready", 32'(lastReady), 32'b0001);
        checkOutput("t1_poly", 32'(lastCalcPoly), 32'b1011);
        checkOutput("t1_latency", 32'(lastLat), 32'd2);
        checkOutput("t1_id", 32'(lastId), 32'd0);
        checkOutput("t1_crc", 32'(lastCrc), 32'b001);
        checkOutput("t1_err", 32'(lastErr), 32'd0);
        checkOutput("t1_err_cnt", 32'(o_err_cnt), 32'd0);

        $display("[TB] check jobs on requester 1");
        applyStimulus(1, 4'b1101, 1'b1, 3'b001, 1'b0, 4'b0000);
        checkOutput("t2_id", 32'(lastId), 32'd1);
        checkOutput("t2_err_good", 32'(lastErr), 32'd0);
        applyStimulus(1, 4'b1101, 1'b1, 3'b011, 1'b0, 4'b0000);
        checkOutput("t2_err_bad", 32'(lastErr), 32'd1);
        checkOutput("t2_err_cnt", 32'(o_err_cnt), 32'd1);

        $display("[TB] four continuous requesters");
        doReset();
        i_req_data = {4'b0111, 4'b1000, 4'b0010, 4'b1101};
        i_req_check = '0;
        i_req_valid = 4'b1111;
        nG = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge i_clk);
            if (o_req_ready != 4'b0000 && nG < 8) begin
                for (int k = 0; k < NREQ; k++)
                    if (o_req_ready[k]) gIdx[nG] = k;
                gCyc[nG] = c;
                nG++;
            end
            tick();
        end
        i_req_valid = '0;
        drainIdle();
        checkOutput("rr_count", 32'(nG >= 6), 32'd1);
        for (int k = 0; k < 6 && k < nG; k++) begin
            checkOutput("rr_order", 32'(gIdx[k]), 32'(k % 4));
            if (k > 0) checkOutput("rr_spacing", 32'(gCyc[k] - gCyc[k-1]), 32'd3);
        end

        $display("[TB] response back-pressure");
        doReset();
        i_rsp_ready = 1'b0;
        i_req_data[2*4 +: 4] = 4'b1101;
        i_req_check[2] = 1'b0;
        i_req_data[3*4 +: 4] = 4'b1000;
        i_req_check[3] = 1'b0;
        i_req_valid = 4'b1100;
        @(negedge i_clk);
        checkOutput("bp_first_grant", 32'(o_req_ready), 32'b0100);
        tick();
        i_req_valid[2] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge i_clk);
            if (o_rsp_valid) seen = 1'b1;
            else tick();
        end
        checkOutput("bp_rsp_seen", 32'(seen), 32'd1);
        for (int s = 0; s < 5; s++) begin
            if (s > 0) begin
                tick();
                @(negedge i_clk);
            end
            checkOutput("bp_valid", 32'(o_rsp_valid), 32'd1);
            checkOutput("bp_id", 32'(o_rsp_id), 32'd2);
            checkOutput("bp_crc", 32'(o_rsp_crc), 32'b001);
            checkOutput("bp_no_ready", 32'(o_req_ready), 32'd0);
        end
        tick();
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        checkOutput("bp_hs_no_ready", 32'(o_req_ready), 32'd0);
        tick();
        @(negedge i_clk);
        checkOutput("bp_next_grant", 32'(o_req_ready), 32'b1000);
        tick();
        i_req_valid = '0;
        drainIdle();

        $display("[TB] polynomial configuration");
        doReset();
        applyStimulus(0, 4'b1101, 1'b0, 3'b000, 1'b1, 4'b1101);
        checkOutput("cfg_inflight_poly", 32'(lastCalcPoly), 32'b1011);
        checkOutput("cfg_inflight_crc", 32'(lastCrc), 32'b001);
        applyStimulus(1, 4'b1101, 1'b0, 3'b000, 1'b1, 4'b0101);
        checkOutput("cfg_new_poly", 32'(lastCalcPoly), 32'b1101);
        checkOutput("cfg_new_crc", 32'(lastCrc), 32'b000);
        checkOutput("cfg_reject_pulse", 32'(lastCfgErr), 32'd1);
        applyStimulus(2, 4'b1000, 1'b0, 3'b000, 1'b0, 4'b0000);
        checkOutput("cfg_kept_poly", 32'(lastCalcPoly), 32'b1101);
        checkOutput("cfg_kept_crc", 32'(lastCrc), 32'b110);
        checkOutput("cfg_pulse_gone", 32'(o_cfg_err), 32'd0);

        $display("[TB] error counter saturation");
        doReset();
        for (int n = 0; n < 258; n++)
            applyStimulus(0, 4'b1101, 1'b1, 3'b011, 1'b0, 4'b0000);
        checkOutput("sat_err_cnt", 32'(o_err_cnt), 32'd255);

        $display("[TB] reset during datapath cycle");
        i_req_data[1*4 +: 4] = 4'b1101;
        i_req_check[1] = 1'b1;
        i_req_crc[1*3 +: 3] = 3'b011;
        i_req_valid[1] = 1'b1;
        @(negedge i_clk);
        checkOutput("rst_grant", 32'(o_req_ready), 32'b0010);
        tick();
        i_req_valid = '0;
        i_rst = 1'b1;
        @(negedge i_clk);
        checkOutput("rst_in_calc", 32'(o_crc_data), 32'b1101);
        tick();
        i_rst = 1'b0;
        i_req_valid = 4'b1111;
        @(negedge i_clk);
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        checkOutput("rst_err_cnt", 32'(o_err_cnt), 32'd0);
        checkOutput("rst_ptr_grant", 32'(o_req_ready), 32'b0001);
        tick();
        i_req_valid = '0;
        drainIdle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
